// File: rtl/gen_active_vertex_single.sv
// Frontier scanner: walks the local active bitmap and emits one global vertex id per set bit.
// Optional GEN_ACTIVE_V_CLEAR_EN adds a zero-write port that clears each word as it is read.

`ifndef V_ID_WIDTH
`define V_ID_WIDTH 32
`endif
`ifndef ITERATION_WIDTH
`define ITERATION_WIDTH 8
`endif
`ifndef CORE_NUM
`define CORE_NUM 4
`endif
`ifndef CORE_NUM_WIDTH
`define CORE_NUM_WIDTH 2
`endif

module gen_active_vertex_single #(
    parameter int unsigned V_ID_WIDTH      = `V_ID_WIDTH,
    parameter int unsigned ITERATION_WIDTH = `ITERATION_WIDTH,
    parameter int unsigned CORE_NUM        = `CORE_NUM,
    parameter int unsigned CORE_NUM_WIDTH  = `CORE_NUM_WIDTH,
    parameter int unsigned CORE_ID         = 0,
    parameter int unsigned BITMAP_WIDTH    = 32,
    parameter int unsigned BITMAP_AWIDTH   = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ITERATION_WIDTH-1:0] start_iteration_id,
    input  logic                       next_stage_full,
    output logic [BITMAP_AWIDTH-1:0]   rd_bitmap_addr,
    output logic                       rd_bitmap_en,
    input  logic [BITMAP_WIDTH-1:0]    bitmap_word,
`ifdef GEN_ACTIVE_V_CLEAR_EN
    output logic [BITMAP_AWIDTH-1:0]   wr_bitmap_addr,
    output logic                       wr_bitmap_en,
`endif
    output logic [V_ID_WIDTH-1:0]      active_v_id,
    output logic                       active_v_valid,
    output logic                       iteration_end,
    output logic                       iteration_end_valid,
    output logic [ITERATION_WIDTH-1:0] iteration_id
);

    localparam int unsigned BitIdxW = (BITMAP_WIDTH > 1) ? $clog2(BITMAP_WIDTH) : 1;

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StScan, StEnd} state_e;

    state_e                     state_q, state_d;
    logic [BITMAP_AWIDTH-1:0]   word_addr_q, word_addr_d;
    logic [BITMAP_WIDTH-1:0]    scan_q, scan_d;
    logic [ITERATION_WIDTH-1:0] iter_id_q, iter_id_d;
    logic [V_ID_WIDTH-1:0]      v_id_q, v_id_d;
    logic                       v_valid_q, v_valid_d;
    logic [BitIdxW-1:0]         low_bit;
    logic [V_ID_WIDTH-1:0]      local_idx;
    logic                       last_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            word_addr_q <= '0;
            scan_q      <= '0;
            iter_id_q   <= '0;
            v_id_q      <= '0;
            v_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            scan_q      <= scan_d;
            iter_id_q   <= iter_id_d;
            v_id_q      <= v_id_d;
            v_valid_q   <= v_valid_d;
        end
    end

    assign last_word = (word_addr_q == {BITMAP_AWIDTH{1'b1}});

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StFetch;
            StFetch: state_d = StWait;
            StWait:  state_d = StScan;
            StScan:  if (scan_q == '0) state_d = last_word ? StEnd : StFetch;
            StEnd:   if (start) state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    // Lowest set bit wins so ids leave in ascending order.
    always_comb begin
        low_bit = '0;
        for (int i = BITMAP_WIDTH - 1; i >= 0; i--) begin
            if (scan_q[i]) low_bit = BitIdxW'(i);
        end
        local_idx = V_ID_WIDTH'(word_addr_q) * V_ID_WIDTH'(BITMAP_WIDTH) + V_ID_WIDTH'(low_bit);
    end

    always_comb begin
        word_addr_d = word_addr_q;
        scan_d      = scan_q;
        iter_id_d   = iter_id_q;
        v_id_d      = v_id_q;
        v_valid_d   = 1'b0;
        unique case (state_q)
            StIdle, StEnd: begin
                if (start) begin
                    iter_id_d   = start_iteration_id;
                    word_addr_d = '0;
                end
            end
            StWait: scan_d = bitmap_word;
            StScan: begin
                if (scan_q == '0) begin
                    if (!last_word) word_addr_d = word_addr_q + BITMAP_AWIDTH'(1);
                end else if (!next_stage_full) begin
                    v_id_d    = (local_idx << CORE_NUM_WIDTH) | V_ID_WIDTH'(CORE_ID % CORE_NUM);
                    v_valid_d = 1'b1;
                    scan_d    = scan_q & (scan_q - BITMAP_WIDTH'(1));
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_bitmap_en        = (state_q == StFetch);
        rd_bitmap_addr      = rd_bitmap_en ? word_addr_q : '0;
        iteration_end       = (state_q == StEnd);
        iteration_end_valid = (state_q == StEnd);
        active_v_id         = v_id_q;
        active_v_valid      = v_valid_q;
        iteration_id        = iter_id_q;
    end

`ifdef GEN_ACTIVE_V_CLEAR_EN
    // The word was already fetched, so zeroing it in WAIT is safe.
    assign wr_bitmap_en   = (state_q == StWait);
    assign wr_bitmap_addr = wr_bitmap_en ? word_addr_q : '0;
`else
    // Read-only bitmap: no write port.
`endif

endmodule

// File: tb/tb_gen_active_vertex_single.sv
// Randomized self-checking bench for gen_active_vertex_single against a bitmap-level model.
// Define GEN_ACTIVE_V_CLEAR_EN to exercise the clear-on-read build.

module tb_gen_active_vertex_single;

    localparam int VW = 32, IW = 8, CN = 32, CNW = 5, CID = 3, BW = 32, AW = 2, NW = 4;

    logic          clk = 1'b0;
    logic          rst, start, next_stage_full;
    logic [IW-1:0] start_iteration_id;
    logic [AW-1:0] rd_bitmap_addr;
    logic          rd_bitmap_en;
    logic [BW-1:0] bitmap_word;
    logic [VW-1:0] active_v_id;
    logic          active_v_valid, iteration_end, iteration_end_valid;
    logic [IW-1:0] iteration_id;
`ifdef GEN_ACTIVE_V_CLEAR_EN
    logic [AW-1:0] wr_bitmap_addr;
    logic          wr_bitmap_en;
`endif

    logic [BW-1:0] mem       [NW];
    logic [BW-1:0] ref_words [NW];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    gen_active_vertex_single #(
        .V_ID_WIDTH(VW), .ITERATION_WIDTH(IW), .CORE_NUM(CN), .CORE_NUM_WIDTH(CNW),
        .CORE_ID(CID), .BITMAP_WIDTH(BW), .BITMAP_AWIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_iteration_id(start_iteration_id),
        .next_stage_full(next_stage_full), .rd_bitmap_addr(rd_bitmap_addr),
        .rd_bitmap_en(rd_bitmap_en), .bitmap_word(bitmap_word),
`ifdef GEN_ACTIVE_V_CLEAR_EN
        .wr_bitmap_addr(wr_bitmap_addr), .wr_bitmap_en(wr_bitmap_en),
`endif
        .active_v_id(active_v_id), .active_v_valid(active_v_valid),
        .iteration_end(iteration_end), .iteration_end_valid(iteration_end_valid),
        .iteration_id(iteration_id)
    );

    // Bitmap RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (rd_bitmap_en) bitmap_word <= mem[rd_bitmap_addr];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_mem();
        for (int w = 0; w < NW; w++) mem[w] = ref_words[w];
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd_en"}, 64'(rd_bitmap_en), 64'd0);
        check_eq({tag, "_rd_addr"}, 64'(rd_bitmap_addr), 64'd0);
        check_eq({tag, "_valid"}, 64'(active_v_valid), 64'd0);
        check_eq({tag, "_id"}, 64'(active_v_id), 64'd0);
        check_eq({tag, "_end"}, 64'(iteration_end), 64'd0);
        check_eq({tag, "_end_valid"}, 64'(iteration_end_valid), 64'd0);
        check_eq({tag, "_iter_id"}, 64'(iteration_id), 64'd0);
    endtask

    // bp_mode: 0 none, 1 random, 2 full during cycles 3..9.
    task automatic run_iter(input logic [IW-1:0] iid, input int bp_mode, input bit glitch);
        int exp_ids[$], exp_cyc[$], got_ids[$], got_cyc[$];
        int t, n, end_cyc_exp, end_cyc_got, wr_cnt;
        bit ended, full_prev, prev_rd, f;
        t = 1;
        for (int w = 0; w < NW; w++) begin
            n = 0;
            for (int b = 0; b < BW; b++) begin
                if (ref_words[w][b]) begin
                    exp_ids.push_back(((w * BW + b) << CNW) | CID);
                    exp_cyc.push_back(t + 3 + n);
                    n++;
                end
            end
            t += 3 + n;
        end
        end_cyc_exp = t;
        ended = 0; full_prev = 0; prev_rd = 0; wr_cnt = 0; end_cyc_got = 0;

        @(negedge clk);
        start = 1'b1; start_iteration_id = iid; next_stage_full = 1'b0;
        @(posedge clk);
        #1 start = 1'b0; start_iteration_id = IW'($urandom);
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check_eq("c1_fetch", 64'(rd_bitmap_en), 64'd1);
                check_eq("c1_addr", 64'(rd_bitmap_addr), 64'd0);
                check_eq("c1_end_drop", 64'(iteration_end), 64'd0);
                check_eq("c1_iter_id", 64'(iteration_id), 64'(iid));
            end
            if (active_v_valid) begin
                check_eq("bp_respect", 64'(full_prev), 64'd0);
                got_ids.push_back(int'(active_v_id));
                got_cyc.push_back(k);
            end
`ifdef GEN_ACTIVE_V_CLEAR_EN
            if (wr_bitmap_en) begin
                check_eq("wr_in_wait", 64'(prev_rd), 64'd1);
                check_eq("wr_addr", 64'(wr_bitmap_addr), 64'(wr_cnt));
                mem[wr_bitmap_addr] = '0;
                wr_cnt++;
            end
`endif
            if (iteration_end) begin
                ended = 1; end_cyc_got = k;
                break;
            end
            prev_rd = rd_bitmap_en;
            case (bp_mode)
                1:       f = ($urandom_range(0, 2) == 0);
                2:       f = (k >= 3 && k <= 9);
                default: f = 1'b0;
            endcase
            next_stage_full = f;
            full_prev = f;
            if (glitch && k == 5) begin
                start = 1'b1; start_iteration_id = 8'd99;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_eq("ended", 64'(ended), 64'd1);
        check_eq("id_count", 64'(got_ids.size()), 64'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size() && i < got_ids.size(); i++) begin
            check_eq("id_value", 64'(got_ids[i]), 64'(exp_ids[i]));
            if (bp_mode == 0) check_eq("id_cycle", 64'(got_cyc[i]), 64'(exp_cyc[i]));
        end
        if (bp_mode == 0) check_eq("end_cycle", 64'(end_cyc_got), 64'(end_cyc_exp));
        if (bp_mode == 2 && got_cyc.size() > 0) begin
            check_eq("bp_first_cycle", 64'(got_cyc[0]), 64'd11);
            check_eq("bp_back_to_back", 64'(got_cyc[got_cyc.size()-1] - got_cyc[0]),
                     64'(got_cyc.size() - 1));
        end
`ifdef GEN_ACTIVE_V_CLEAR_EN
        check_eq("wr_count", 64'(wr_cnt), 64'(NW));
        for (int w = 0; w < NW; w++) ref_words[w] = '0;
`endif
        next_stage_full = 1'b0;
        for (int h = 0; h < 3; h++) begin
            check_eq("end_hold", 64'(iteration_end), 64'd1);
            check_eq("end_valid_hold", 64'(iteration_end_valid), 64'd1);
            check_eq("end_iter_id", 64'(iteration_id), 64'(iid));
            check_eq("end_no_read", 64'(rd_bitmap_en), 64'd0);
            check_eq("end_no_valid", 64'(active_v_valid), 64'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_iteration_id = '0; next_stage_full = 1'b0;
        for (int w = 0; w < NW; w++) begin
            mem[w] = '0; ref_words[w] = '0;
        end
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        ref_words = '{32'h1, 32'h0, 32'h0, 32'h0};
        load_mem(); run_iter(8'd5, 0, 0);
        ref_words = '{32'h0, 32'h8000_0000, 32'h0, 32'h0};
        load_mem(); run_iter(8'd7, 0, 0);
        ref_words = '{32'hF, 32'h0, 32'h0, 32'h0};
        load_mem(); run_iter(8'd4, 2, 0);
        ref_words = '{32'h5, 32'h0, 32'h1, 32'h0};
        load_mem(); run_iter(8'd6, 0, 0);

        // Reset mid-scan of a dense word.
        ref_words = '{32'hFF, 32'h0, 32'h0, 32'h0};
        load_mem();
        @(negedge clk);
        start = 1'b1; start_iteration_id = 8'd12;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_valid", 64'(active_v_valid), 64'd1);
        rst = 1'b1;
        #1 check_all_zero("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("post_rst_no_read", 64'(rd_bitmap_en), 64'd0);
            check_eq("post_rst_no_valid", 64'(active_v_valid), 64'd0);
        end
        load_mem(); run_iter(8'd13, 0, 0);

        // Second pass over the same bitmap without reloading it.
        ref_words = '{32'h11, 32'h0, 32'h8000_0001, 32'h2};
        load_mem(); run_iter(8'd9, 0, 1);
        run_iter(8'd10, 0, 0);

        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < NW; w++)
                ref_words[w] = ($urandom_range(0, 3) == 0) ? '0 : ($urandom & $urandom);
            load_mem();
            run_iter(IW'($urandom), 1, bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gen_active_vertex_single.md
# gen_active_vertex_single

Per-core frontier scanner that produces the active-vertex stream consumed by the active-vertex-offset read stage. At each iteration start it walks this core's local active bitmap one word at a time. For every set bit it emits one global vertex id, in ascending order, while honouring that stage's `stage_full` backpressure. After the last word it holds `iteration_end` asserted until the next iteration starts.

## Interface
Parameters:
- `V_ID_WIDTH`, default `` `V_ID_WIDTH ``: vertex id width.
- `ITERATION_WIDTH`, default `` `ITERATION_WIDTH ``: iteration id width.
- `CORE_NUM`, default `` `CORE_NUM ``: number of cores; a power of two.
- `CORE_NUM_WIDTH`, default `` `CORE_NUM_WIDTH ``: log2(`CORE_NUM`).
- `CORE_ID`, default 0: this core's index.
- `BITMAP_WIDTH`, default 32: bits per bitmap word.
- `BITMAP_AWIDTH`, default 10: bitmap address width. Word count is 2^`BITMAP_AWIDTH`.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins an iteration.
- `start_iteration_id`  in  `ITERATION_WIDTH`: iteration number, sampled with `start`.
- `next_stage_full`  in  1: `stage_full` from the downstream read stage (a prog_full flag).
- `rd_bitmap_addr`  out  `BITMAP_AWIDTH`: bitmap read address.
- `rd_bitmap_en`  out  1: bitmap read enable.
- `bitmap_word`  in  `BITMAP_WIDTH`: bitmap read data; 1-cycle read latency.
- `active_v_id`  out  `V_ID_WIDTH`: emitted global vertex id.
- `active_v_valid`  out  1: one-cycle qualifier for `active_v_id`.
- `iteration_end`, `iteration_end_valid`  out  1 each: end-of-frontier flags, always driven equal.
- `iteration_id`  out  `ITERATION_WIDTH`: current iteration number.

## Operation
States: IDLE, FETCH, WAIT, SCAN, END.

- **IDLE**
  - `start` latches `iteration_id` <= `start_iteration_id` and clears `word_addr` to 0.
  - Next state is FETCH.
- **FETCH**
  - `rd_bitmap_en` = 1 and `rd_bitmap_addr` = `word_addr`, both combinational from state.
  - Next state is WAIT.
- **WAIT**
  - `scan_reg` <= `bitmap_word`.
  - Next state is SCAN.
- **SCAN** when `scan_reg` == 0:
  - If `word_addr` == 2^`BITMAP_AWIDTH` - 1, next state is END.
  - Otherwise `word_addr` increments and the next state is FETCH.
- **SCAN** when `scan_reg` != 0 and `next_stage_full` == 0:
  - b = index of the lowest set bit.
  - `active_v_id` <= ((`word_addr` * `BITMAP_WIDTH` + b) << `CORE_NUM_WIDTH`) | `CORE_ID`, truncated to `V_ID_WIDTH`.
  - `active_v_valid` <= 1.
  - Bit b of `scan_reg` is cleared.
- **SCAN** when `scan_reg` != 0 and `next_stage_full` == 1:
  - `scan_reg` holds and nothing is emitted.
- **END**
  - `iteration_end` = `iteration_end_valid` = 1, held until `start` or reset. The downstream stage requires both flags held steadily for its wait window.
  - `start` latches a new `iteration_id`, clears `word_addr` and moves to FETCH. The end flags drop in the following cycle.
- `start` is ignored in FETCH, WAIT and SCAN.
- `iteration_id` is held constant for the whole iteration.
- Every set bit is emitted exactly once per iteration: no losses, no duplicates.

## Timing
- **Reset values**
  - Assertion of `rst` at any time forces state IDLE.
  - All outputs go to 0: `rd_bitmap_en`, `active_v_valid`, `active_v_id`, `iteration_end`, `iteration_end_valid`, `iteration_id`, `rd_bitmap_addr`.
  - Reset mid-scan abandons the iteration. No further reads or emissions occur until the next `start`.
- **Latency**
  - `start` is sampled at cycle 0; FETCH is cycle 1, WAIT cycle 2, SCAN cycle 3.
  - The first `active_v_valid` appears in cycle 4.
- **Throughput**
  - An empty word costs 3 cycles.
  - A word with n set bits costs 3+n cycles when there is no backpressure.
  - Peak rate is one id per cycle.
- **Backpressure**
  - `next_stage_full` is sampled in the emitting cycle.
  - The downstream flag lags its FIFO by one cycle; its prog_full margin absorbs the one in-flight id.
- **Widths**
  - `word_addr` is compared, never wrapped past the last word.

## Configuration
- `GEN_ACTIVE_V_CLEAR_EN` defined:
  - Adds output ports `wr_bitmap_addr` (`BITMAP_AWIDTH` bits) and `wr_bitmap_en` (1 bit); the write data is implicitly all-zeros.
  - In every WAIT cycle, `wr_bitmap_en` = 1 and `wr_bitmap_addr` = `word_addr`, so each word is cleared as it is consumed.
  - `wr_bitmap_en` resets to 0.
- `GEN_ACTIVE_V_CLEAR_EN` undefined: the write ports do not exist and the bitmap is read-only.

## Test plan
- **Single bit.** Setup: `CORE_NUM`=32, `CORE_ID`=3, `BITMAP_AWIDTH`=2, word0=0x1, other words 0, `start` with id 5.
  - Required: exactly one valid, with `active_v_id`=3, in cycle 4.
  - Then `iteration_end`/`iteration_end_valid`=1 held, and `iteration_id`=5.
- **High bit.** Setup: word1=0x8000_0000, same parameters.
  - Required: one id = (32+31)*32+3 = 2019.
- **Backpressure.** Setup: word0=0xF, `next_stage_full` high for cycles 3-9.
  - Required: no valid during cycles 4-10.
  - Then ids 3, 35, 67, 99 on consecutive cycles, none lost or duplicated.
- **Restart from END.** Stimulus: `start` with id 6 while in END.
  - Required: end flags drop the next cycle, `iteration_id`=6, and the rescan begins with FETCH.
- **Reset mid-scan.** Stimulus: assert `rst` during SCAN of a word holding 0xFF.
  - Required: all outputs 0 immediately, no further `rd_bitmap_en`, and restart works normally.
- **Clear option.** Setup: `GEN_ACTIVE_V_CLEAR_EN` defined.
  - Required: one `wr_bitmap_en` pulse per word, addresses 0..3, each in a WAIT cycle.
  - A second iteration emits nothing and ends.
